// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, shift right, shift left and parallel load,
// with synchronous clear, a saturating shift counter and a full-pass pulse.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    shift_cnt,
  output logic             pass_done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SR   = 2'b01,
    MODE_SL   = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_now;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CW'(WIDTH)) return c;
    else                 return c + CW'(1);
  endfunction

  always_comb begin
    reg_d     = reg_q;
    sout_d    = sout_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    shift_now = 1'b0;
    if (clr) begin
      reg_d  = RESET_VAL;
      sout_d = 1'b0;
      cnt_d  = '0;
    end else if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SR: begin
          reg_d     = {sin_r, reg_q[WIDTH-1:1]};
          sout_d    = reg_q[0];
          shift_now = 1'b1;
        end
        MODE_SL: begin
          reg_d     = {reg_q[WIDTH-2:0], sin_l};
          sout_d    = reg_q[WIDTH-1];
          shift_now = 1'b1;
        end
        MODE_LOAD: begin
          reg_d = d;
          cnt_d = '0;
        end
        default: ;
      endcase
      // Pulse only on the shift that lands exactly on WIDTH, never while saturated.
      if (shift_now) begin
        cnt_d  = sat_inc(cnt_q);
        done_d = (cnt_q == CW'(WIDTH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_q  <= RESET_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = reg_q;
  assign sout      = sout_q;
  assign shift_cnt = cnt_q;
  assign pass_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit and a 4-bit (RESET_VAL=9) instance share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rn8 = 1'b0;
  logic       rn4 = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [7:0] d_in = 8'h00;

  logic [7:0] q8;
  logic       sout8, pass8;
  logic [3:0] cnt8;
  logic [3:0] q4;
  logic       sout4, pass4;
  logic [2:0] cnt4;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .clk(clk), .reset_n(rn8), .clr(clr), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .d(d_in),
    .q(q8), .sout(sout8), .shift_cnt(cnt8), .pass_done(pass8)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h9)) dut4 (
    .clk(clk), .reset_n(rn4), .clr(clr), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .d(d_in[3:0]),
    .q(q4), .sout(sout4), .shift_cnt(cnt4), .pass_done(pass4)
  );

  typedef struct {
    int q;
    int s;
    int c;
    int p;
  } mstate_t;

  mstate_t m8, m4;

  function automatic mstate_t reset_state(int rv);
    mstate_t n;
    n.q = rv; n.s = 0; n.c = 0; n.p = 0;
    return n;
  endfunction

  // One clock edge of the register, written from the behavioural rules.
  function automatic mstate_t step(mstate_t s, int w, int rv, logic c, logic e,
                                   logic [1:0] m, logic sr, logic sl, logic [7:0] dv);
    mstate_t n;
    int mask;
    mask = (1 << w) - 1;
    n = s;
    n.p = 0;
    if (c) begin
      n = reset_state(rv);
    end else if (e && m != 2'b00) begin
      if (m == 2'b11) begin
        n.q = int'(dv) & mask;
        n.c = 0;
      end else begin
        if (m == 2'b01) begin
          n.s = s.q & 1;
          n.q = (s.q >> 1) | (int'(sr) << (w - 1));
        end else begin
          n.s = (s.q >> (w - 1)) & 1;
          n.q = ((s.q << 1) | int'(sl)) & mask;
        end
        n.p = (s.c == w - 1) ? 1 : 0;
        n.c = (s.c + 1 > w) ? w : s.c + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rn8) begin
    if (!rn8) m8 <= reset_state(8'h00);
    else      m8 <= step(m8, 8, 8'h00, clr, en, mode, sin_r, sin_l, d_in);
  end

  always @(posedge clk or negedge rn4) begin
    if (!rn4) m4 <= reset_state(4'h9);
    else      m4 <= step(m4, 4, 4'h9, clr, en, mode, sin_r, sin_l, d_in);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("q8",    32'(q8),    m8.q);
    chk("sout8", 32'(sout8), m8.s);
    chk("cnt8",  32'(cnt8),  m8.c);
    chk("pass8", 32'(pass8), m8.p);
    chk("q4",    32'(q4),    m4.q);
    chk("sout4", 32'(sout4), m4.s);
    chk("cnt4",  32'(cnt4),  m4.c);
    chk("pass4", 32'(pass4), m4.p);
  end

  // Apply inputs, then wait past the next edge and past the compare process.
  task automatic cyc(input logic c, input logic e, input logic [1:0] m,
                     input logic sr, input logic sl, input logic [7:0] dv);
    clr = c; en = e; mode = m; sin_r = sr; sin_l = sl; d_in = dv;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] seq;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q8",    32'(q8),    32'h00);
    chk("rst_cnt8",  32'(cnt8),  32'h0);
    chk("rst_pass8", 32'(pass8), 32'h0);
    chk("rst_sout8", 32'(sout8), 32'h0);
    chk("rst_q4",    32'(q4),    32'h9);
    rn8 = 1'b1;
    rn4 = 1'b1;

    // Load then single right shift
    cyc(0, 1, 2'b11, 0, 0, 8'hA5);
    cyc(0, 1, 2'b01, 0, 0, 8'h00);
    chk("t2_q",    32'(q8),    32'h52);
    chk("t2_sout", 32'(sout8), 32'h1);
    chk("t2_cnt",  32'(cnt8),  32'h1);

    // Async reset mid-cycle, no clock edge needed
    cyc(0, 1, 2'b11, 0, 0, 8'hA5);
    cyc(0, 0, 2'b00, 0, 0, 8'h00);
    cyc(0, 1, 2'b01, 0, 0, 8'h00);
    rn8 = 1'b0;
    #1;
    chk("t1_q",    32'(q8),    32'h00);
    chk("t1_cnt",  32'(cnt8),  32'h0);
    chk("t1_pass", 32'(pass8), 32'h0);
    #1;
    rn8 = 1'b1;

    // Eight left shifts through a full word, then one more
    seq = 8'b1000_0001;
    cyc(0, 1, 2'b11, 0, 0, 8'h81);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b10, 0, 1, 8'h00);
      chk("t3_sout", 32'(sout8), 32'(seq[7-i]));
      chk("t3_pass", 32'(pass8), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("t3_q",   32'(q8),   32'hFF);
    chk("t3_cnt", 32'(cnt8), 32'h8);
    cyc(0, 1, 2'b10, 0, 1, 8'h00);
    chk("t3_cnt9",  32'(cnt8),  32'h8);
    chk("t3_pass9", 32'(pass8), 32'h0);

    // Enable low holds everything
    cyc(0, 1, 2'b11, 0, 0, 8'h3C);
    repeat (4) cyc(0, 0, 2'b01, 1, 1, 8'h00);
    chk("t4_q",   32'(q8),   32'h3C);
    chk("t4_cnt", 32'(cnt8), 32'h0);

    // Clear beats load
    cyc(1, 1, 2'b11, 0, 0, 8'hFF);
    chk("t5_q",   32'(q8),   32'h00);
    chk("t5_cnt", 32'(cnt8), 32'h0);
    chk("t5_q4",  32'(q4),   32'h9);

    // 4-bit instance: partial count aborted by reset, then a full right pass
    repeat (3) cyc(0, 1, 2'b01, 1, 0, 8'h00);
    chk("t6_cnt3", 32'(cnt4), 32'h3);
    rn4 = 1'b0;
    #1;
    chk("t6_rq",   32'(q4),   32'h9);
    chk("t6_rcnt", 32'(cnt4), 32'h0);
    #1;
    rn4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'b01, 1, 0, 8'h00);
      chk("t6_pass", 32'(pass4), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("t6_q",   32'(q4),   32'hF);
    chk("t6_cnt", 32'(cnt4), 32'h4);

    // Randomized traffic, including rare clears and async resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
          2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 1) == 0) rn8 = 1'b0;
        else                           rn4 = 1'b0;
        #1;
        rn8 = 1'b1;
        rn4 = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
